// File: rtl/regfile_read.sv
// Operand-read stage: architectural register file, per-register busy
// scoreboard, RAW/WAW stall generation, same-cycle writeback bypass and a
// one-entry operand register towards execute.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready. The producer keeps its payload stable while valid is
// high and ready is low. Here id_ready is combinational and may depend on the
// id_* fields; ex_valid/ex_* are registered and hold while !ex_ready.
module regfile_read #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_we,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] busy_mask
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    logic            wb_hit1;
    logic            wb_hit2;
    logic            wb_hit_rd;
    logic            src1_haz;
    logic            src2_haz;
    logic            waw;
    logic            accept;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;

    assign wb_hit1   = wb_en && (wb_addr == id_rs1);
    assign wb_hit2   = wb_en && (wb_addr == id_rs2);
    assign wb_hit_rd = wb_en && (wb_addr == id_rd);

    // A writeback arriving on the same edge resolves the hazard.
    assign src1_haz = id_rs1_used && (id_rs1 != '0) && busy[id_rs1] && !wb_hit1;
    assign src2_haz = id_rs2_used && (id_rs2 != '0) && busy[id_rs2] && !wb_hit2;
    assign waw      = id_rd_we && (id_rd != '0) && busy[id_rd] && !wb_hit_rd;

    assign id_ready = !rst && !src1_haz && !src2_haz && !waw && (!ex_valid || ex_ready);
    assign accept   = id_valid && id_ready;

    assign busy_mask = busy;

    // Operand select: x0 reads zero, then same-cycle bypass, then the array.
    always_comb begin
        op1_sel = rf[id_rs1];
        op2_sel = rf[id_rs2];
        if (id_rs1 == '0) begin
            op1_sel = '0;
        end else if (wb_hit1) begin
            op1_sel = wb_data;
        end
        if (id_rs2 == '0) begin
            op2_sel = '0;
        end else if (wb_hit2) begin
            op2_sel = wb_data;
        end
    end

    // Next scoreboard: writeback clears, accepted writer sets (set wins).
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (accept && id_rd_we) begin
            busy_nxt[id_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Register array write port; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Operand pipeline register towards execute; data holds when not loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_rs1_data <= op1_sel;
            ex_rs2_data <= op2_sel;
            ex_rd       <= id_rd;
            ex_rd_we    <= id_rd_we;
        end else if (ex_ready) begin
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_read.sv
// Self-checking bench for regfile_read: directed scenarios followed by
// randomized traffic, all compared against a behavioural register-file model.
module tb_regfile_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;

    regfile_read #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_mask(busy_mask)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_rf [32];
    bit          m_busy [32];
    logic        m_exv;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    logic [4:0]  m_rd;
    logic        m_we;

    int n_checks = 0;
    int n_pass   = 0;
    logic sampled_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    // Value an instruction reading register r sees at this cycle.
    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_rf[r];
    endfunction

    // Register r is pending unless x0, not busy, or written back this cycle.
    function automatic bit model_pending(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_exv = 0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_we = 0;
    endtask

    // Driver helpers.
    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we);
        id_valid = 1; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    // One clock: entered and left at negedge with inputs already driven.
    task automatic cycle();
        bit exp_rdy;
        bit acc;
        logic [31:0] v1;
        logic [31:0] v2;
        #1;
        exp_rdy = !(id_rs1_used && model_pending(id_rs1)) &&
                  !(id_rs2_used && model_pending(id_rs2)) &&
                  !(id_rd_we && model_pending(id_rd)) &&
                  (!m_exv || ex_ready);
        sampled_ready = id_ready;
        chk("id_ready", {31'b0, id_ready}, {31'b0, exp_rdy});
        acc = id_valid && exp_rdy;
        v1 = model_read(id_rs1);
        v2 = model_read(id_rs2);
        if (wb_en && wb_addr != 0) begin
            m_rf[wb_addr]   = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (acc) begin
            m_exv = 1; m_d1 = v1; m_d2 = v2; m_rd = id_rd; m_we = id_rd_we;
            if (id_rd_we && id_rd != 0) m_busy[id_rd] = 1'b1;
        end else if (ex_ready) begin
            m_exv = 0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_exv});
        chk("ex_rs1_data", ex_rs1_data, m_d1);
        chk("ex_rs2_data", ex_rs2_data, m_d2);
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
        chk("ex_rd_we", {31'b0, ex_rd_we}, {31'b0, m_we});
        chk("busy_mask", busy_mask, model_mask());
        @(negedge clk);
    endtask

    // Assert reset off-edge, check the immediate effect, release at next negedge.
    task automatic do_reset(input int offset);
        #(offset);
        rst = 1;
        #1;
        chk("rst_busy_mask", busy_mask, 32'h0);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'h0);
        chk("rst_ex_rs1_data", ex_rs1_data, 32'h0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1;
        set_idle();
        model_reset();
        @(negedge clk);
        do_reset(0);

        // Reset sequence: first instruction after reset.
        issue(0, 1, 0, 1, 3, 1);
        cycle();
        chk("first_ready", {31'b0, sampled_ready}, 32'h1);
        chk("first_busy", busy_mask, 32'h0000_0008);
        set_idle();

        // Write then read.
        wb(5, 32'hDEADBEEF);
        cycle();
        set_idle();
        issue(5, 1, 0, 0, 0, 0);
        cycle();
        chk("wr_then_rd", ex_rs1_data, 32'hDEADBEEF);
        // Same-cycle bypass.
        issue(0, 0, 6, 1, 0, 0);
        wb(6, 32'h12345678);
        cycle();
        chk("bypass", ex_rs2_data, 32'h12345678);
        set_idle();

        // RAW stall, resolved by the writeback.
        issue(0, 0, 0, 0, 7, 1);
        cycle();
        issue(7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("raw_stall", {31'b0, sampled_ready}, 32'h0);
        end
        wb(7, 32'hA5A5A5A5);
        cycle();
        chk("raw_release", {31'b0, sampled_ready}, 32'h1);
        chk("raw_data", ex_rs1_data, 32'hA5A5A5A5);
        chk("raw_busy7", {31'b0, busy_mask[7]}, 32'h0);
        set_idle();
        // Unused source never stalls.
        issue(0, 0, 0, 0, 7, 1);
        cycle();
        issue(7, 0, 0, 0, 0, 0);
        cycle();
        chk("unused_src", {31'b0, sampled_ready}, 32'h1);
        set_idle();
        wb(7, 32'h0000_0077);
        cycle();
        set_idle();

        // x0 handling.
        wb(0, 32'hFFFFFFFF);
        cycle();
        set_idle();
        issue(0, 1, 0, 1, 0, 0);
        cycle();
        chk("x0_read", ex_rs1_data, 32'h0);
        issue(0, 0, 0, 0, 0, 1);
        cycle();
        issue(0, 1, 0, 0, 0, 0);
        cycle();
        chk("x0_no_stall", {31'b0, sampled_ready}, 32'h1);
        chk("x0_busy0", {31'b0, busy_mask[0]}, 32'h0);
        set_idle();

        // Backpressure.
        issue(1, 1, 2, 1, 10, 1);
        cycle();
        issue(0, 0, 0, 0, 11, 1);
        ex_ready = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("bp_ready", {31'b0, sampled_ready}, 32'h0);
        end
        ex_ready = 1;
        cycle();
        chk("bp_release", {31'b0, sampled_ready}, 32'h1);
        set_idle();

        // WAW stall, then issue coinciding with writeback of the same register.
        issue(0, 0, 0, 0, 9, 1);
        cycle();
        cycle();
        chk("waw_stall", {31'b0, sampled_ready}, 32'h0);
        wb(9, 32'h0000_0999);
        cycle();
        chk("waw_release", {31'b0, sampled_ready}, 32'h1);
        chk("waw_set_wins", {31'b0, busy_mask[9]}, 32'h1);
        set_idle();

        // Reset mid-operation while decode is stalled on x8.
        do_reset(0);
        issue(0, 0, 0, 0, 7, 1); cycle();
        issue(0, 0, 0, 0, 8, 1); cycle();
        issue(0, 0, 0, 0, 9, 1); cycle();
        issue(8, 1, 0, 0, 0, 0);
        cycle();
        chk("pre_rst_mask", busy_mask, 32'h0000_0380);
        chk("pre_rst_stall", {31'b0, sampled_ready}, 32'h0);
        do_reset(2);
        cycle();
        chk("post_rst_accept", {31'b0, sampled_ready}, 32'h1);
        chk("post_rst_data", ex_rs1_data, 32'h0);
        set_idle();

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 7));
            id_rd_we    = 1'($urandom_range(0, 1));
            wb_en       = 1'($urandom_range(0, 1));
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            ex_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
